rv_wb_trace: RTL and testbench
==============================

# rv_wb_trace

Write-back retirement trace source for the RISC-V core. Sits beside the write-back stage, captures every architectural register write (PC, destination, data) into a small FIFO, and presents it on a valid/ready stream to the testbench monitor. This makes the core the producing end of the monitor path. It tags entries with a sequence number so the monitor can detect dropped records.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- XLEN, 64, register/PC data width

Ports:
- clk  input  1  core clock; single clock domain
- rst  input  1  synchronous, active-high reset
- wb_reg_write  input  1  write-back stage commits a register write this cycle
- wb_rd  input  5  destination register of the write-back
- wb_write_data  input  XLEN  value written
- wb_pc  input  XLEN  PC of the retiring instruction
- trace_valid  output  1  head entry available
- trace_ready  input  1  monitor accepts head entry
- trace_pc  output  XLEN  head entry PC
- trace_rd  output  5  head entry destination
- trace_data  output  XLEN  head entry data
- trace_seq  output  32  head entry sequence number
- count  output  $clog2(DEPTH)+1  current occupancy
- overflow  output  1  sticky; set when a record was dropped
- drop_cnt  output  16  dropped-record count, saturates at 16'hFFFF

## Operation
- Qualifying write-back: wb_reg_write=1, subject to the filter in Configuration.
- seq_ctr (32 bit, internal) increments by 1 on every qualifying write-back, accepted or dropped; wraps 32'hFFFF_FFFF -> 0. The enqueued record carries the pre-increment value. Gaps in trace_seq therefore expose drops.
- Pop: trace_valid && trace_ready at a rising edge removes the head.
- Push: a qualifying write-back is enqueued if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle.
- Drop: a qualifying write-back with count==DEPTH and no pop.
  - Record discarded.
  - overflow set to 1.
  - drop_cnt incremented, saturating.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Pointers: read/write indices of $clog2(DEPTH) bits; wrap modulo DEPTH.
- trace_valid = (count != 0).
- trace_* payload is driven from the FIFO head.
  - Stable while trace_valid && !trace_ready.
  - Don't-care when trace_valid=0.
- overflow and drop_cnt clear only on rst.
- Reset values:
  - trace_valid=0, count=0, overflow=0, drop_cnt=0.
  - seq_ctr=0; pointers=0.
  - trace_pc, trace_rd, trace_data, trace_seq = 0.
- Reset mid-operation: all stored entries discarded. A write-back or trace_ready in the same cycle as rst is ignored.

## Timing
- Latency: write-back sampled at edge N -> trace_valid=1 and payload valid after edge N, with no combinational bypass from wb_* to trace_*.
- Throughput: one push and one pop per cycle sustained.
- trace_ready may depend combinationally on trace_valid. trace_valid never depends combinationally on trace_ready.
- count, overflow, and drop_cnt are registered and update at the same edge as the push/pop/drop that changes them.
- Full FIFO with ready=1 and a write-back in the same cycle: no drop; occupancy stays DEPTH.

## Configuration
- Macro: RV_WB_TRACE_X0_FILTER_EN.
- Defined:
  - Write-backs with wb_rd==0 are not qualifying.
  - They are not enqueued, do not increment seq_ctr, and never cause a drop.
- Undefined:
  - Every wb_reg_write=1 is qualifying, including rd=0.
  - x0 records appear in the trace with the sequence number advanced.

## Test plan
- Reset then single write-back pc=0x1000, rd=5, data=0xDEAD_BEEF, ready held 1:
  - trace_valid high one cycle later with that payload and trace_seq=0.
  - count returns to 0 after the pop.
- Stream of 20 back-to-back write-backs with ready=1:
  - 20 records out in order, trace_seq 0..19.
  - overflow=0, drop_cnt=0.
- DEPTH=8, ready=0, 10 write-backs:
  - count=8, overflow=1, drop_cnt=2.
  - Releasing ready yields seq 0..7.
  - Next write-back gets seq=10.
- Full FIFO, ready=1, write-back in the same cycle:
  - count stays 8, no drop.
  - Popped head is seq 0; new tail has the next seq.
- Backpressure: ready toggled 1/0 each cycle under continuous write-backs:
  - Payload stable while ready=0.
  - No reordering; drops only once count reaches 8.
- Reset asserted with count=5:
  - Next cycle trace_valid=0, count=0, overflow=0.
  - First post-reset record has trace_seq=0.
- With the macro defined, write-backs to rd=0,3,0,7:
  - Only rd=3 (seq 0) and rd=7 (seq 1) appear.
- Without the macro, same stimulus:
  - All four appear, seq 0..3.

Source files
------------

// File: rtl/rv_wb_trace_if.sv
// rtl/rv_wb_trace_if.sv - write-back capture and trace stream signal bundle
//
// Ports (signals carried by the interface):
//   wb_reg_write, wb_rd, wb_write_data, wb_pc : write-back commit from the core
//   trace_valid, trace_ready                  : trace stream handshake
//   trace_pc, trace_rd, trace_data, trace_seq : trace stream payload (FIFO head)
// Modports:
//   master : the trace source (consumes write-backs, drives the trace stream)
//   slave  : the core/monitor side (drives write-backs and trace_ready)
interface rv_wb_trace_if #(
  parameter int XLEN = 64
);
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_write_data;
  logic [XLEN-1:0] wb_pc;

  logic            trace_valid;
  logic            trace_ready;
  logic [XLEN-1:0] trace_pc;
  logic [4:0]      trace_rd;
  logic [XLEN-1:0] trace_data;
  logic [31:0]     trace_seq;

  modport master (
    input  wb_reg_write,
    input  wb_rd,
    input  wb_write_data,
    input  wb_pc,
    input  trace_ready,
    output trace_valid,
    output trace_pc,
    output trace_rd,
    output trace_data,
    output trace_seq
  );

  modport slave (
    output wb_reg_write,
    output wb_rd,
    output wb_write_data,
    output wb_pc,
    output trace_ready,
    input  trace_valid,
    input  trace_pc,
    input  trace_rd,
    input  trace_data,
    input  trace_seq
  );
endinterface

// File: rtl/rv_wb_trace.sv
// rtl/rv_wb_trace.sv - write-back retirement trace FIFO with sequence tagging
//
// Parameters: DEPTH (FIFO entries, power of two 2..64), XLEN (PC/data width).
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   bus       : rv_wb_trace_if.master - write-back capture in, trace stream out
//   count     : current FIFO occupancy
//   overflow  : sticky, set when a qualifying write-back was dropped
//   drop_cnt  : number of dropped records, saturating at 16'hFFFF
// Option macro: RV_WB_TRACE_X0_FILTER_EN - when defined, write-backs to x0
// are ignored entirely (no record, no sequence advance, no drop).
module rv_wb_trace #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  rv_wb_trace_if.master            bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [31:0]     seq;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic [31:0]     seq_q, seq_d;

  logic            qual;
  logic            pop;
  logic            push;
  logic            drop;

  always_comb begin
`ifdef RV_WB_TRACE_X0_FILTER_EN
    qual = bus.wb_reg_write && (bus.wb_rd != 5'd0);
`else
    qual = bus.wb_reg_write;
`endif
    pop  = (count_q != '0) && bus.trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push = qual && ((count_q != FULL_CNT) || pop);
    drop = qual && (count_q == FULL_CNT) && !pop;

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q].pc   = bus.wb_pc;
      mem_d[wr_ptr_q].rd   = bus.wb_rd;
      mem_d[wr_ptr_q].data = bus.wb_write_data;
      mem_d[wr_ptr_q].seq  = seq_q;
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Sequence advances on dropped records too, so gaps reveal the loss.
    seq_d      = qual ? seq_q + 32'd1 : seq_q;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Storage is cleared so the head payload reads as zero after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 16'd0;
      seq_q      <= 32'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      seq_q      <= seq_d;
    end
  end

  assign bus.trace_valid = (count_q != '0);
  assign bus.trace_pc    = mem_q[rd_ptr_q].pc;
  assign bus.trace_rd    = mem_q[rd_ptr_q].rd;
  assign bus.trace_data  = mem_q[rd_ptr_q].data;
  assign bus.trace_seq   = mem_q[rd_ptr_q].seq;

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_rv_wb_trace.sv
// tb/tb_rv_wb_trace.sv - self-checking bench for rv_wb_trace
module tb_rv_wb_trace;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   drop_cnt;

  always #5 clk = ~clk;

  rv_wb_trace_if #(.XLEN(XLEN)) bus ();

  rv_wb_trace #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] seq;
  } rec_t;

  rec_t        mq[$];
  logic [31:0] m_seq;
  bit          m_ovf;
  int          m_drop;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("valid", 64'(bus.trace_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("head_pc", bus.trace_pc, mq[0].pc);
      chk("head_rd", 64'(bus.trace_rd), 64'(mq[0].rd));
      chk("head_data", bus.trace_data, mq[0].data);
      chk("head_seq", 64'(bus.trace_seq), 64'(mq[0].seq));
    end
  endtask

  // One clock: drive inputs, advance the queue model, sample #1 after the edge.
  task automatic cyc(input bit r, input bit wb, input logic [4:0] rd,
                     input logic [63:0] pc, input logic [63:0] data, input bit rdy);
    bit          pop, qual, stalled;
    logic [63:0] s_pc;
    logic [31:0] s_seq;
    rec_t        e;
    rst                  = r;
    bus.wb_reg_write     = wb;
    bus.wb_rd            = rd;
    bus.wb_pc            = pc;
    bus.wb_write_data    = data;
    bus.trace_ready      = rdy;
    stalled = bus.trace_valid && !rdy && !r;
    s_pc    = bus.trace_pc;
    s_seq   = bus.trace_seq;
    if (r) begin
      mq.delete();
      m_seq  = 0;
      m_ovf  = 0;
      m_drop = 0;
    end else begin
      pop  = (mq.size() != 0) && rdy;
      qual = wb;
`ifdef RV_WB_TRACE_X0_FILTER_EN
      if (rd == 5'd0) qual = 0;
`endif
      if (pop) e = mq.pop_front();
      if (qual) begin
        if (mq.size() < DEPTH) begin
          e.pc = pc; e.rd = rd; e.data = data; e.seq = m_seq;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drop < 65535) m_drop++;
        end
        m_seq = m_seq + 1;
      end
    end
    @(posedge clk);
    #1;
    check_model();
    if (stalled) begin
      chk("stall_pc_stable", bus.trace_pc, s_pc);
      chk("stall_seq_stable", 64'(bus.trace_seq), 64'(s_seq));
    end
  endtask

  typedef struct {
    bit          r, wb;
    logic [4:0]  rd;
    logic [63:0] pc, data;
    bit          rdy;
    bit          e_valid;
    int          e_cnt;
    bit          e_ovf;
    int          e_drop;
    logic [31:0] e_seq;
    logic [63:0] e_pc;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic void addv(input bit r, input bit wb, input logic [4:0] rd,
                               input logic [63:0] pc, input logic [63:0] data, input bit rdy,
                               input bit ev, input int ec, input bit eo, input int ed,
                               input logic [31:0] es, input logic [63:0] epc,
                               input logic [4:0] erd, input logic [63:0] edata);
    vec_t v;
    v.r = r; v.wb = wb; v.rd = rd; v.pc = pc; v.data = data; v.rdy = rdy;
    v.e_valid = ev; v.e_cnt = ec; v.e_ovf = eo; v.e_drop = ed;
    v.e_seq = es; v.e_pc = epc; v.e_rd = erd; v.e_data = edata;
    tbl.push_back(v);
  endfunction

  int          n_exp;
  logic [4:0]  x0_rd[4];
  logic [4:0]  exp_rd[$];
  logic [31:0] exp_seq[$];

  initial begin
    // Single write-back, then drain.
    addv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 1, 5, 64'h1000, 64'hDEAD_BEEF, 1,  1, 1, 0, 0, 0, 64'h1000, 5, 64'hDEAD_BEEF);
    addv(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);
    // Ten write-backs into a stalled FIFO, release, then one more.
    addv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      addv(0, 1, 5'(i + 1), 64'h2000 + 64'(4 * i), 64'(i * 'h11), 0,
           1, (i + 1 > 8) ? 8 : i + 1, i >= 8, (i >= 8) ? i - 7 : 0, 0, 64'h2000, 1, 0);
    for (int k = 0; k < 8; k++)
      addv(0, 0, 0, 0, 0, 1,
           k < 7, 7 - k, 1, 2, 32'(k + 1), 64'h2000 + 64'(4 * (k + 1)), 5'(k + 2), 64'((k + 1) * 'h11));
    addv(0, 1, 9, 64'h3000, 64'hAB, 0,  1, 1, 1, 2, 10, 64'h3000, 9, 64'hAB);
    // Twenty back-to-back records with ready held high.
    addv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      addv(0, 1, 5'((i % 31) + 1), 64'h4000 + 64'(4 * i), 64'(i), 1,
           1, 1, 0, 0, 32'(i), 64'h4000 + 64'(4 * i), 5'((i % 31) + 1), 64'(i));
    addv(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].wb, tbl[i].rd, tbl[i].pc, tbl[i].data, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.trace_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].e_drop));
      if (tbl[i].e_valid || tbl[i].r) begin
        chk($sformatf("tbl%0d_seq", i), 64'(bus.trace_seq), 64'(tbl[i].e_seq));
        chk($sformatf("tbl%0d_pc", i), bus.trace_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_rd", i), 64'(bus.trace_rd), 64'(tbl[i].e_rd));
        chk($sformatf("tbl%0d_data", i), bus.trace_data, tbl[i].e_data);
      end
    end

    // Full FIFO, ready and a write-back in the same cycle.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 5'd1, 64'(i), 64'(i), 0);
    cyc(0, 1, 5'd2, 64'h88, 64'h88, 1);
    chk("full_wb_count", 64'(count), 64'd8);
    chk("full_wb_drop", 64'(drop_cnt), 64'd0);
    chk("full_wb_ovf", 64'(overflow), 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk("full_drain_seq", 64'(bus.trace_seq), 64'(k + 1));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("full_drain_empty", 64'(bus.trace_valid), 64'd0);

    // Reset while holding five entries, with a write-back and ready in that cycle.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 5'd4, 64'(i), 64'(i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    chk("pre_rst_count", 64'(count), 64'd5);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    cyc(1, 1, 5'd4, 64'h55, 64'h55, 1);
    chk("rst_valid", 64'(bus.trace_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    cyc(0, 1, 5'd4, 64'h66, 64'h66, 0);
    chk("post_rst_seq", 64'(bus.trace_seq), 64'd0);

    // x0 write-backs with and without the filter.
    x0_rd[0] = 5'd0; x0_rd[1] = 5'd3; x0_rd[2] = 5'd0; x0_rd[3] = 5'd7;
`ifdef RV_WB_TRACE_X0_FILTER_EN
    exp_rd = '{5'd3, 5'd7};
    exp_seq = '{32'd0, 32'd1};
`else
    exp_rd = '{5'd0, 5'd3, 5'd0, 5'd7};
    exp_seq = '{32'd0, 32'd1, 32'd2, 32'd3};
`endif
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, x0_rd[i], 64'h100 + 64'(i), 64'(i), 0);
    n_exp = exp_rd.size();
    chk("x0_count", 64'(count), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      chk("x0_rd", 64'(bus.trace_rd), 64'(exp_rd[i]));
      chk("x0_seq", 64'(bus.trace_seq), 64'(exp_seq[i]));
      cyc(0, 0, 0, 0, 0, 1);
    end
    chk("x0_empty", 64'(bus.trace_valid), 64'd0);

    // Ready toggling under continuous write-backs.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      cyc(0, 1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, {$urandom, $urandom}, i[0]);

    // Random traffic against the queue model.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) < 7), 5'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 9) < 5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
